// File: rtl/amul_dot_acc.sv
// Dot-product accumulator built on an approximate 8x8 multiplier.
// Accumulates both the approximate products and the exact-minus-approximate error per result.
module amul_dot_acc #(
  parameter int unsigned LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_sum,
  output logic [23:0] out_err
);

  typedef enum logic [1:0] {StAcc, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [7:0]  cnt_q;
  logic        s1_valid_q, s1_last_q;
  logic [15:0] s1_approx_q;
  logic [23:0] s1_err_q;
  logic [23:0] acc_sum_q, acc_err_q;

  logic        hs, last;
  logic [15:0] p1, p2, approx, exact;
  logic [23:0] term_err;

  assign hs   = in_valid & in_ready;
  assign last = (cnt_q == 8'(LEN - 1));

  // Truncated partial-product array: rows 0 and 1 are replaced by two sparse correction terms.
  always_comb begin
    p1     = '0;
    p1[7]  = (y[6] & x[0]) | (y[5] & x[1]);
    p1[8]  = (y[7] & x[0]) & (y[6] & x[1]);
    p2     = '0;
    p2[7]  = (y[7] & x[0]) | (y[6] & x[1]);
    p2[8]  = y[7] & x[1];
    approx = ((16'(y) * 16'(x[7:2])) << 2) + p1 + p2;
    exact  = 16'(y) * 16'(x);
    term_err = 24'(exact) - 24'(approx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAcc;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAcc:   if (hs && last) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  if (out_ready) state_d = StAcc;
      default: state_d = StAcc;
    endcase
    if (clr) state_d = StAcc;
  end

  always_comb begin
    in_ready  = (state_q == StAcc);
    out_valid = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_approx_q <= '0;
      s1_err_q    <= '0;
      acc_sum_q   <= '0;
      acc_err_q   <= '0;
      out_sum     <= '0;
      out_err     <= '0;
    end else if (clr) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_approx_q <= '0;
      s1_err_q    <= '0;
      acc_sum_q   <= '0;
      acc_err_q   <= '0;
      out_sum     <= '0;
      out_err     <= '0;
    end else begin
      s1_valid_q <= hs;
      if (hs) begin
        cnt_q       <= last ? 8'd0 : cnt_q + 8'd1;
        s1_approx_q <= approx;
        s1_err_q    <= term_err;
        s1_last_q   <= last;
      end
      if (s1_valid_q) begin
        acc_sum_q <= acc_sum_q + 24'(s1_approx_q);
        acc_err_q <= acc_err_q + s1_err_q;
      end else if (state_q == StDone && out_ready) begin
        acc_sum_q <= '0;
        acc_err_q <= '0;
      end
      // Final term bypasses the accumulator so the result is ready on entry to DONE.
      if (s1_valid_q && s1_last_q) begin
        out_sum <= acc_sum_q + 24'(s1_approx_q);
        out_err <= acc_err_q + s1_err_q;
      end
    end
  end

endmodule

// File: tb/tb_amul_dot_acc.sv
// Directed bench for amul_dot_acc: five instances with LEN = 1, 2, 4, 8, 256 share stimulus,
// each driven only through its own in_valid.
module tb_amul_dot_acc;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        out_ready;
  logic [7:0]  x, y;
  logic [4:0]  iv, ir, ov;
  logic [23:0] os [5];
  logic [23:0] oe [5];

  int n_checks = 0;
  int n_errors = 0;

  localparam int K1 = 0, K2 = 1, K4 = 2, K8 = 3, K256 = 4;

  for (genvar g = 0; g < 5; g++) begin : gen_dut
    amul_dot_acc #(
      .LEN((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 256)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .in_valid (iv[g]),
      .in_ready (ir[g]),
      .x        (x),
      .y        (y),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .out_sum  (os[g]),
      .out_err  (oe[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic term(input int k, input logic [7:0] xv, input logic [7:0] yv);
    x     = xv;
    y     = yv;
    iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
  endtask

  // Call right after the last-term handshake: DRAIN cycle, then result in DONE.
  task automatic expect_result(input int k, input string tag, input logic [23:0] s,
                               input logic [23:0] e);
    check({tag, "_drain_ov"}, 32'(ov[k]), 32'd0);
    check({tag, "_drain_ir"}, 32'(ir[k]), 32'd0);
    @(posedge clk); #1;
    check({tag, "_ov"}, 32'(ov[k]), 32'd1);
    check({tag, "_sum"}, 32'(os[k]), 32'(s));
    check({tag, "_err"}, 32'(oe[k]), 32'(e));
  endtask

  task automatic consume(input int k, input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_ov"}, 32'(ov[k]), 32'd0);
    check({tag, "_post_ir"}, 32'(ir[k]), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; out_ready = 1'b0; iv = '0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ir", 32'(ir[K4]), 32'd1);
    check("rst_ov", 32'(ov[K4]), 32'd0);
    check("rst_sum", 32'(os[K4]), 32'd0);
    check("rst_err", 32'(oe[K4]), 32'd0);
    rst_n = 1'b1;

    // Four max-operand terms: A=65028, E-A=-3 each.
    for (int i = 0; i < 4; i++) term(K4, 8'd255, 8'd255);
    expect_result(K4, "max4", 24'd260112, 24'hFFFFF4);
    consume(K4, "max4");

    // Mixed terms: A = 0, 768, 12, 0; E-A = +1, -3, 0, 0.
    term(K4, 8'd1, 8'd1);
    term(K4, 8'd3, 8'd255);
    term(K4, 8'd4, 8'd3);
    term(K4, 8'd0, 8'd200);
    expect_result(K4, "mix4", 24'd780, 24'hFFFFFE);
    consume(K4, "mix4");

    // LEN=1: every term is last.
    term(K1, 8'd3, 8'd255);
    expect_result(K1, "len1a", 24'd768, 24'hFFFFFD);
    consume(K1, "len1a");
    term(K1, 8'd1, 8'd1);
    expect_result(K1, "len1b", 24'd0, 24'd1);
    consume(K1, "len1b");

    // Backpressure: result held while in_valid is ignored.
    term(K2, 8'd4, 8'd3);
    term(K2, 8'd4, 8'd3);
    expect_result(K2, "bp", 24'd24, 24'd0);
    x = 8'd255; y = 8'd255; iv[K2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_ir", 32'(ir[K2]), 32'd0);
      check("bp_hold_sum", 32'(os[K2]), 32'd24);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; iv[K2] = 1'b0;
    check("bp_rel_ir", 32'(ir[K2]), 32'd1);
    check("bp_rel_ov", 32'(ov[K2]), 32'd0);
    term(K2, 8'd1, 8'd1);
    term(K2, 8'd1, 8'd1);
    expect_result(K2, "bp2", 24'd0, 24'd2);
    consume(K2, "bp2");

    // clr after three terms discards them and restarts the term count.
    for (int i = 0; i < 3; i++) term(K8, 8'd255, 8'd255);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_ov", 32'(ov[K8]), 32'd0);
    check("clr_ir", 32'(ir[K8]), 32'd1);
    for (int i = 0; i < 7; i++) term(K8, 8'd4, 8'd1);
    check("clr_not_last", 32'(ir[K8]), 32'd1);
    term(K8, 8'd4, 8'd1);
    expect_result(K8, "clr8", 24'd32, 24'd0);
    consume(K8, "clr8");

    // Async reset mid-dot-product.
    for (int i = 0; i < 5; i++) term(K8, 8'd255, 8'd255);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sum", 32'(os[K8]), 32'd0);
    check("arst_err", 32'(oe[K8]), 32'd0);
    check("arst_ir", 32'(ir[K8]), 32'd1);
    check("arst_ov", 32'(ov[K8]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) term(K8, 8'd255, 8'd255);
    expect_result(K8, "arst8", 24'd520224, 24'hFFFFE8);
    consume(K8, "arst8");

    // LEN=256 at full scale, then a second run proves the counter wrapped to 0.
    for (int i = 0; i < 255; i++) term(K256, 8'd255, 8'd255);
    check("l256_ov", 32'(ov[K256]), 32'd0);
    check("l256_ir", 32'(ir[K256]), 32'd1);
    term(K256, 8'd255, 8'd255);
    expect_result(K256, "l256", 24'd16647168, 24'hFFFD00);
    consume(K256, "l256");
    for (int i = 0; i < 255; i++) term(K256, 8'd1, 8'd1);
    check("l256w_ir", 32'(ir[K256]), 32'd1);
    term(K256, 8'd1, 8'd1);
    expect_result(K256, "l256w", 24'd0, 24'd256);
    consume(K256, "l256w");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
